// File: rtl/comb_decode_if.sv
// comb_decode_if: code-word request and decode-result handshake bundle.
interface comb_decode_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data;
  logic       found;
  logic       multi;
  logic [4:0] match_cnt;
  modport master (output in_valid, code, out_ready,
                  input  in_ready, out_valid, data, found, multi, match_cnt);
  modport slave  (input  in_valid, code, out_ready,
                  output in_ready, out_valid, data, found, multi, match_cnt);
endinterface

// File: rtl/comb_decode.sv
// comb_decode: sequential inverse of the 4-bit forward map f, scanning idx 0..15 for preimages.
// Optional COMB_DECODE_EARLY_EXIT_EN stops the scan at the first match.
module comb_decode (
  input  logic         clk,
  input  logic         rst_n,
  comb_decode_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t     state_q;
  logic [3:0] idx_q, code_q, data_q, f_o;
  logic       found_q, multi_q, hit;
  logic [4:0] cnt_q, cnt_d;
  always_comb begin
    f_o[3] = ~idx_q[0] | idx_q[3] | (~idx_q[2] & ~idx_q[1]) | (idx_q[2] & idx_q[1]);
    f_o[2] = (~idx_q[2] & ~idx_q[0]) | (idx_q[1] & ~idx_q[0]) | (idx_q[3] & ~idx_q[2])
           | (idx_q[3] & ~idx_q[0]) | (~idx_q[3] & idx_q[2] & idx_q[0]);
    f_o[1] = (~idx_q[3] & ~idx_q[2] & idx_q[0]) | (~idx_q[3] & idx_q[2] & ~idx_q[1])
           | (idx_q[2] & ~idx_q[1] & idx_q[0]);
    f_o[0] = ~idx_q[3] & ~idx_q[2] & ~idx_q[1] & idx_q[0];
  end
  assign hit   = f_o == code_q;
  assign cnt_d = cnt_q + {4'd0, hit};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      code_q  <= '0;
      data_q  <= '0;
      found_q <= 1'b0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else
      case (state_q)
        IDLE: if (bus.in_valid) begin
          state_q <= SCAN;
          code_q  <= bus.code;
          idx_q   <= '0;
          data_q  <= '0;
          found_q <= 1'b0;
          multi_q <= 1'b0;
          cnt_q   <= '0;
        end
        SCAN: begin
          idx_q <= idx_q + 4'd1;
          cnt_q <= cnt_d;
          if (hit && !found_q) begin
            data_q  <= idx_q;
            found_q <= 1'b1;
          end
`ifdef COMB_DECODE_EARLY_EXIT_EN
          if (hit || idx_q == 4'hF) state_q <= DONE;
`else
          multi_q <= cnt_d >= 5'd2;
          if (idx_q == 4'hF) state_q <= DONE;
`endif
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.data      = data_q;
  assign bus.found     = found_q;
  assign bus.multi     = multi_q;
  assign bus.match_cnt = cnt_q;
endmodule
